// File: rtl/ethnet_gen_if.sv
// Ethernet NoC stream interface: one beat per valid/ready handshake, 256-bit payload,
// 4-bit destination address and sop/eop framing.
interface t_ETH_STREAM;
   logic         valid;
   logic [255:0] data;
   logic [3:0]   addr;
   logic         sop;
   logic         eop;
   logic         ready;

   modport tx (output valid, output data, output addr, output sop, output eop, input ready);
   modport rx (input valid, input data, input addr, input sop, input eop, output ready);
endinterface

// File: rtl/ethnet_gen.sv
// Transmit-side traffic generator: fixed-length packets whose beats carry a 64-bit running
// beat counter. Define ETHNET_GEN_ERR_INJECT_EN to build the single-beat error injection path.
module ethnet_gen #(
   parameter int unsigned PKT_BEATS  = 8,
   parameter int unsigned GAP_CYCLES = 4,
   parameter logic [3:0]  DEST_ADDR  = 4'h0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic [31:0] num_pkts,
   input  logic        inject_err,
   output logic        busy,
   output logic        done,
   output logic [31:0] o_pkt_count,
   output logic [63:0] o_counter,
   t_ETH_STREAM.tx     tx
);

   localparam int IDX_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BEATS - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   beat_idx_q, beat_idx_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic               valid_q, valid_d;
   logic               sop_q, sop_d;
   logic               eop_q, eop_d;
   logic [95:0]        data_q, data_d;
   logic [3:0]         addr_q, addr_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [31:0]        pkt_count_q, pkt_count_d;
   logic [63:0]        counter_q, counter_d;
   logic [31:0]        num_pkts_q, num_pkts_d;

   logic               xfer;
   logic               load_beat;
   logic [IDX_W-1:0]   load_idx;
   logic               corrupt_ok;

   assign xfer = valid_q & tx.ready;

   always_comb begin
      state_d     = state_q;
      beat_idx_d  = beat_idx_q;
      gap_cnt_d   = gap_cnt_q;
      valid_d     = valid_q;
      sop_d       = sop_q;
      eop_d       = eop_q;
      data_d      = data_q;
      addr_d      = addr_q;
      done_d      = done_q;
      pkt_count_d = pkt_count_q;
      counter_d   = counter_q;
      num_pkts_d  = num_pkts_q;
      load_beat   = 1'b0;
      load_idx    = '0;

      unique case (state_q)
         IDLE: begin
            if (!enable) begin
               done_d = 1'b0;
            end else if (!done_q) begin
               state_d     = SEND;
               pkt_count_d = '0;
               num_pkts_d  = num_pkts;
               load_beat   = 1'b1;
            end
         end

         SEND: begin
            if (xfer) begin
               counter_d = counter_q + 64'd1;
               valid_d   = 1'b0;
               sop_d     = 1'b0;
               eop_d     = 1'b0;
               if (eop_q) begin
                  pkt_count_d = pkt_count_q + 32'd1;
                  beat_idx_d  = '0;
                  if ((num_pkts_q != 32'd0) && (pkt_count_d == num_pkts_q)) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else if (GAP_CYCLES > 0) begin
                     state_d   = GAP;
                     gap_cnt_d = '0;
                  end else if (enable) begin
                     // No gap configured: next packet's sop beat follows immediately.
                     load_beat = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  load_beat = 1'b1;
                  load_idx  = beat_idx_q + IDX_W'(1);
               end
            end
         end

         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               if (enable) begin
                  state_d   = SEND;
                  load_beat = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end

         default: state_d = IDLE;
      endcase

      // Beat content is built from the post-update counters: they equal the values at transfer.
      if (load_beat) begin
         valid_d    = 1'b1;
         beat_idx_d = load_idx;
         sop_d      = (load_idx == '0);
         eop_d      = (load_idx == LAST_IDX);
         addr_d     = DEST_ADDR;
         data_d     = {pkt_count_d, counter_d ^ {63'd0, corrupt_ok}};
      end

      busy_d = (state_d != IDLE);
   end

`ifdef ETHNET_GEN_ERR_INJECT_EN
   logic err_armed_q, err_armed_d;
   logic err_beat_q, err_beat_d;

   // err_beat marks the presented beat that carries the corruption; the flag drops on its transfer.
   always_comb begin
      corrupt_ok  = (err_armed_q & ~err_beat_q) | (inject_err & ~err_armed_q);
      err_armed_d = (err_armed_q & ~(xfer & err_beat_q)) | (inject_err & ~err_armed_q);
      err_beat_d  = err_beat_q;
      if (xfer) begin
         err_beat_d = 1'b0;
      end
      if (load_beat) begin
         err_beat_d = corrupt_ok;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_armed_q <= 1'b0;
         err_beat_q  <= 1'b0;
      end else begin
         err_armed_q <= err_armed_d;
         err_beat_q  <= err_beat_d;
      end
   end
`else
   logic unused_inject_err;
   assign unused_inject_err = inject_err;
   assign corrupt_ok        = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         beat_idx_q  <= '0;
         gap_cnt_q   <= '0;
         valid_q     <= 1'b0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         data_q      <= '0;
         addr_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pkt_count_q <= '0;
         counter_q   <= '0;
         num_pkts_q  <= '0;
      end else begin
         state_q     <= state_d;
         beat_idx_q  <= beat_idx_d;
         gap_cnt_q   <= gap_cnt_d;
         valid_q     <= valid_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         data_q      <= data_d;
         addr_q      <= addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pkt_count_q <= pkt_count_d;
         counter_q   <= counter_d;
         num_pkts_q  <= num_pkts_d;
      end
   end

   assign tx.valid    = valid_q;
   assign tx.data     = {160'd0, data_q};
   assign tx.addr     = addr_q;
   assign tx.sop      = sop_q;
   assign tx.eop      = eop_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign o_pkt_count = pkt_count_q;
   assign o_counter   = counter_q;

endmodule

// File: tb/tb_ethnet_gen.sv
// Directed bench for ethnet_gen: a 4-beat/2-gap instance for framing, backpressure, disable and
// reset scenarios, and a 1-beat/no-gap instance for counter wrap with back-to-back beats.
module tb_ethnet_gen;

   logic        clk = 1'b0;
   logic        resetn;
   logic        enable, enable_w;
   logic [31:0] num_pkts, num_pkts_w;
   logic        inject_err, inject_err_w;
   logic        busy, busy_w, done, done_w;
   logic [31:0] o_pkt_count, o_pkt_count_w;
   logic [63:0] o_counter, o_counter_w;

   t_ETH_STREAM eth();
   t_ETH_STREAM ethw();

   ethnet_gen #(.PKT_BEATS(4), .GAP_CYCLES(2), .DEST_ADDR(4'h5)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .num_pkts(num_pkts), .inject_err(inject_err),
      .busy(busy), .done(done), .o_pkt_count(o_pkt_count), .o_counter(o_counter), .tx(eth)
   );

   ethnet_gen #(.PKT_BEATS(1), .GAP_CYCLES(0), .DEST_ADDR(4'h0)) dut_w (
      .clk(clk), .resetn(resetn), .enable(enable_w), .num_pkts(num_pkts_w), .inject_err(inject_err_w),
      .busy(busy_w), .done(done_w), .o_pkt_count(o_pkt_count_w), .o_counter(o_counter_w), .tx(ethw)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   int unsigned cyc_cnt = 0;

   logic [255:0] cap_data[$];
   logic         cap_sop[$];
   logic         cap_eop[$];
   logic [3:0]   cap_addr[$];
   int unsigned  cap_cyc[$];
   logic [255:0] wcap_data[$];
   logic         wcap_sop[$];
   logic         wcap_eop[$];
   int unsigned  wcap_cyc[$];

   logic         smp_valid, smp_ready, smp_sop, smp_eop, smp_busy;
   logic [255:0] smp_data;

   // One clock: drive inputs just after posedge, sample everything at the following negedge.
   task automatic cycle(input logic rdy, input logic inj);
      eth.ready  = rdy;
      inject_err = inj;
      @(negedge clk);
      cyc_cnt++;
      smp_valid = eth.valid;
      smp_ready = eth.ready;
      smp_sop   = eth.sop;
      smp_eop   = eth.eop;
      smp_data  = eth.data;
      smp_busy  = busy;
      if (eth.valid && eth.ready) begin
         cap_data.push_back(eth.data);
         cap_sop.push_back(eth.sop);
         cap_eop.push_back(eth.eop);
         cap_addr.push_back(eth.addr);
         cap_cyc.push_back(cyc_cnt);
      end
      if (ethw.valid && ethw.ready) begin
         wcap_data.push_back(ethw.data);
         wcap_sop.push_back(ethw.sop);
         wcap_eop.push_back(ethw.eop);
         wcap_cyc.push_back(cyc_cnt);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_caps();
      cap_data.delete(); cap_sop.delete(); cap_eop.delete(); cap_addr.delete(); cap_cyc.delete();
      wcap_data.delete(); wcap_sop.delete(); wcap_eop.delete(); wcap_cyc.delete();
   endtask

   task automatic test_reset();
      resetn = 1'b1;
      #2 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if (eth.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", eth.valid); end
      tests_run++; if (eth.sop !== 1'b0 || eth.eop !== 1'b0) begin tests_failed++; $display("FAIL reset_sop_eop: got %b%b expected 00", eth.sop, eth.eop); end
      tests_run++; if (eth.data !== 256'd0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", eth.data); end
      tests_run++; if (eth.addr !== 4'd0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", eth.addr); end
      tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
      tests_run++; if (o_pkt_count !== 32'd0) begin tests_failed++; $display("FAIL reset_pkt_count: got %0d expected 0", o_pkt_count); end
      tests_run++; if (o_counter !== 64'd0) begin tests_failed++; $display("FAIL reset_counter: got %0d expected 0", o_counter); end
      tests_run++; if (ethw.valid !== 1'b0 || o_counter_w !== 64'd0) begin tests_failed++; $display("FAIL reset_wrap_dut: got valid %b counter %0d expected 0 0", ethw.valid, o_counter_w); end
      @(negedge clk) resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      clear_caps();
      num_pkts = 32'd2;
      enable   = 1'b1;
      for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0);
      tests_run++; if (cap_data.size() != 8) begin tests_failed++; $display("FAIL basic_beat_count: got %0d expected 8", cap_data.size()); end
      for (int k = 0; k < 8 && k < cap_data.size(); k++) begin
         tests_run++; if (cap_data[k][63:0] !== 64'(k)) begin tests_failed++; $display("FAIL basic_data[%0d]: got %0d expected %0d", k, cap_data[k][63:0], k); end
         tests_run++; if (cap_data[k][95:64] !== 32'(k / 4)) begin tests_failed++; $display("FAIL basic_pktfield[%0d]: got %0d expected %0d", k, cap_data[k][95:64], k / 4); end
         tests_run++; if (cap_data[k][255:96] !== 160'd0) begin tests_failed++; $display("FAIL basic_upper[%0d]: got %h expected 0", k, cap_data[k][255:96]); end
         tests_run++; if (cap_sop[k] !== (k % 4 == 0)) begin tests_failed++; $display("FAIL basic_sop[%0d]: got %b expected %b", k, cap_sop[k], (k % 4 == 0)); end
         tests_run++; if (cap_eop[k] !== (k % 4 == 3)) begin tests_failed++; $display("FAIL basic_eop[%0d]: got %b expected %b", k, cap_eop[k], (k % 4 == 3)); end
         tests_run++; if (cap_addr[k] !== 4'h5) begin tests_failed++; $display("FAIL basic_addr[%0d]: got %h expected 5", k, cap_addr[k]); end
      end
      if (cap_cyc.size() >= 5) begin
         tests_run++; if (cap_cyc[3] - cap_cyc[0] != 3) begin tests_failed++; $display("FAIL basic_pkt_contig: got %0d expected 3", cap_cyc[3] - cap_cyc[0]); end
         tests_run++; if (cap_cyc[4] - cap_cyc[3] != 3) begin tests_failed++; $display("FAIL basic_gap: got %0d cycles expected 3", cap_cyc[4] - cap_cyc[3]); end
      end
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL basic_done: got %b expected 1", done); end
      tests_run++; if (o_pkt_count !== 32'd2) begin tests_failed++; $display("FAIL basic_pkt_count: got %0d expected 2", o_pkt_count); end
      tests_run++; if (o_counter !== 64'd8) begin tests_failed++; $display("FAIL basic_counter: got %0d expected 8", o_counter); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy: got %b expected 0", busy); end
      enable = 1'b0;
      cycle(1'b1, 1'b0);
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_clear: got %b expected 0", done); end
   endtask

   task automatic test_backpressure();
      logic [15:0]  pat;
      logic         prev_stall;
      logic [255:0] prev_data;
      logic         prev_sop, prev_eop;
      logic         fin;
      pat        = 16'hB2E5;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_sop   = 1'b0;
      prev_eop   = 1'b0;
      fin        = 1'b0;
      clear_caps();
      num_pkts = 32'd3;
      enable   = 1'b1;
      for (int i = 0; i < 300 && !fin; i++) begin
         cycle(pat[i % 16], 1'b0);
         if (prev_stall) begin
            tests_run++; if (smp_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_hold cyc %0d: got %b expected 1", cyc_cnt, smp_valid); end
            tests_run++; if (smp_data !== prev_data || smp_sop !== prev_sop || smp_eop !== prev_eop) begin tests_failed++; $display("FAIL bp_beat_hold cyc %0d: got %h expected %h", cyc_cnt, smp_data[95:0], prev_data[95:0]); end
         end
         prev_stall = smp_valid && !smp_ready;
         prev_data  = smp_data;
         prev_sop   = smp_sop;
         prev_eop   = smp_eop;
         if (done) fin = 1'b1;
      end
      tests_run++; if (fin !== 1'b1) begin tests_failed++; $display("FAIL bp_timeout: got done %b expected 1", fin); end
      tests_run++; if (cap_data.size() != 12) begin tests_failed++; $display("FAIL bp_beat_count: got %0d expected 12", cap_data.size()); end
      for (int k = 0; k < 12 && k < cap_data.size(); k++) begin
         tests_run++; if (cap_data[k][63:0] !== 64'(8 + k)) begin tests_failed++; $display("FAIL bp_data[%0d]: got %0d expected %0d", k, cap_data[k][63:0], 8 + k); end
         tests_run++; if (cap_data[k][95:64] !== 32'(k / 4)) begin tests_failed++; $display("FAIL bp_pktfield[%0d]: got %0d expected %0d", k, cap_data[k][95:64], k / 4); end
         tests_run++; if (cap_sop[k] !== (k % 4 == 0) || cap_eop[k] !== (k % 4 == 3)) begin tests_failed++; $display("FAIL bp_framing[%0d]: got sop %b eop %b", k, cap_sop[k], cap_eop[k]); end
      end
      enable = 1'b0;
      cycle(1'b1, 1'b0);
   endtask

   task automatic test_disable_mid();
      int   nbeats;
      logic v[10];
      logic b[10];
      nbeats   = 0;
      num_pkts = 32'd0;
      enable   = 1'b1;
      for (int i = 0; i < 20 && nbeats < 2; i++) begin
         cycle(1'b1, 1'b0);
         if (smp_valid && smp_ready) nbeats++;
      end
      tests_run++; if (nbeats != 2) begin tests_failed++; $display("FAIL dis_start: got %0d beats expected 2", nbeats); end
      enable = 1'b0;
      clear_caps();
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b0);
         v[i] = smp_valid;
         b[i] = smp_busy;
      end
      tests_run++; if (cap_data.size() != 2) begin tests_failed++; $display("FAIL dis_beat_count: got %0d expected 2", cap_data.size()); end
      if (cap_data.size() >= 2) begin
         tests_run++; if (cap_data[0][63:0] !== 64'd22 || cap_data[1][63:0] !== 64'd23) begin tests_failed++; $display("FAIL dis_data: got %0d %0d expected 22 23", cap_data[0][63:0], cap_data[1][63:0]); end
         tests_run++; if (cap_sop[0] !== 1'b0 || cap_sop[1] !== 1'b0) begin tests_failed++; $display("FAIL dis_sop: got %b%b expected 00", cap_sop[0], cap_sop[1]); end
         tests_run++; if (cap_eop[0] !== 1'b0 || cap_eop[1] !== 1'b1) begin tests_failed++; $display("FAIL dis_eop: got %b%b expected 01", cap_eop[0], cap_eop[1]); end
      end
      tests_run++; if (v[2] !== 1'b0 || v[3] !== 1'b0 || b[2] !== 1'b1 || b[3] !== 1'b1) begin tests_failed++; $display("FAIL dis_gap: got valid %b%b busy %b%b expected 00 11", v[2], v[3], b[2], b[3]); end
      tests_run++; if (b[4] !== 1'b0 || v[9] !== 1'b0) begin tests_failed++; $display("FAIL dis_idle: got busy %b valid %b expected 0 0", b[4], v[9]); end
      tests_run++; if (o_counter !== 64'd24 || o_pkt_count !== 32'd1) begin tests_failed++; $display("FAIL dis_counts: got %0d %0d expected 24 1", o_counter, o_pkt_count); end
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL dis_done: got %b expected 0", done); end
   endtask

   task automatic test_async_reset();
      int nbeats;
      nbeats = 0;
      enable = 1'b1;
      for (int i = 0; i < 20 && nbeats < 2; i++) begin
         cycle(1'b1, 1'b0);
         if (smp_valid && smp_ready) nbeats++;
      end
      tests_run++; if (eth.valid !== 1'b1 || eth.data[63:0] !== 64'd26) begin tests_failed++; $display("FAIL arst_beat2: got valid %b data %0d expected 1 26", eth.valid, eth.data[63:0]); end
      #2 resetn = 1'b0;
      #1;
      tests_run++; if (eth.valid !== 1'b0 || eth.sop !== 1'b0) begin tests_failed++; $display("FAIL arst_valid_drop: got valid %b sop %b expected 0 0", eth.valid, eth.sop); end
      tests_run++; if (busy !== 1'b0 || o_counter !== 64'd0 || o_pkt_count !== 32'd0) begin tests_failed++; $display("FAIL arst_state: got busy %b counter %0d pkts %0d expected 0 0 0", busy, o_counter, o_pkt_count); end
      @(negedge clk) resetn = 1'b1;
      @(posedge clk);
      #1;
      clear_caps();
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
      tests_run++; if (cap_data.size() < 1) begin tests_failed++; $display("FAIL arst_restart: got %0d beats expected >0", cap_data.size()); end
      if (cap_data.size() >= 1) begin
         tests_run++; if (cap_sop[0] !== 1'b1 || cap_data[0][95:0] !== 96'd0) begin tests_failed++; $display("FAIL arst_first_beat: got sop %b data %h expected 1 0", cap_sop[0], cap_data[0][95:0]); end
      end
      enable = 1'b0;
      for (int i = 0; i < 20 && busy; i++) cycle(1'b1, 1'b0);
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL arst_wind_down: got busy %b expected 0", busy); end
   endtask

   task automatic test_wrap_back_to_back();
      clear_caps();
      num_pkts_w = 32'd0;
      dut_w.counter_q = 64'hFFFF_FFFF_FFFF_FFFE;
      enable_w = 1'b1;
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
      enable_w = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
      tests_run++; if (wcap_data.size() < 3) begin tests_failed++; $display("FAIL wrap_beat_count: got %0d expected >=3", wcap_data.size()); end
      if (wcap_data.size() >= 3) begin
         tests_run++; if (wcap_data[0][63:0] !== 64'hFFFF_FFFF_FFFF_FFFE) begin tests_failed++; $display("FAIL wrap_beat0: got %h expected fffffffffffffffe", wcap_data[0][63:0]); end
         tests_run++; if (wcap_data[1][63:0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin tests_failed++; $display("FAIL wrap_beat1: got %h expected ffffffffffffffff", wcap_data[1][63:0]); end
         tests_run++; if (wcap_data[2][63:0] !== 64'd0) begin tests_failed++; $display("FAIL wrap_beat2: got %h expected 0", wcap_data[2][63:0]); end
         tests_run++; if (wcap_data[2][95:64] !== 32'd2) begin tests_failed++; $display("FAIL wrap_pktfield: got %0d expected 2", wcap_data[2][95:64]); end
         tests_run++; if (wcap_cyc[1] - wcap_cyc[0] != 1 || wcap_cyc[2] - wcap_cyc[1] != 1) begin tests_failed++; $display("FAIL wrap_b2b: got spacing %0d %0d expected 1 1", wcap_cyc[1] - wcap_cyc[0], wcap_cyc[2] - wcap_cyc[1]); end
         for (int k = 0; k < 3; k++) begin
            tests_run++; if (wcap_sop[k] !== 1'b1 || wcap_eop[k] !== 1'b1) begin tests_failed++; $display("FAIL wrap_sop_eop[%0d]: got %b%b expected 11", k, wcap_sop[k], wcap_eop[k]); end
         end
      end
   endtask

   task automatic test_err_inject();
      logic        injected;
      logic        inj;
      int          errs;
      logic [63:0] exp5;
      int          exp_errs;
`ifdef ETHNET_GEN_ERR_INJECT_EN
      exp5     = 64'd4;
      exp_errs = 1;
`else
      exp5     = 64'd5;
      exp_errs = 0;
`endif
      injected = 1'b0;
      errs     = 0;
      resetn   = 1'b0;
      @(negedge clk) resetn = 1'b1;
      @(posedge clk);
      #1;
      clear_caps();
      num_pkts = 32'd2;
      enable   = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         inj = !injected && eth.valid && (eth.data[63:0] == 64'd4);
         if (inj) injected = 1'b1;
         cycle(1'b1, inj);
      end
      tests_run++; if (injected !== 1'b1) begin tests_failed++; $display("FAIL err_pulse_issued: got %b expected 1", injected); end
      tests_run++; if (cap_data.size() != 8) begin tests_failed++; $display("FAIL err_beat_count: got %0d expected 8", cap_data.size()); end
      if (cap_data.size() >= 8) begin
         for (int k = 0; k < 8; k++) if (cap_data[k][63:0] != 64'(k)) errs++;
         tests_run++; if (cap_data[5][63:0] !== exp5) begin tests_failed++; $display("FAIL err_beat5: got %0d expected %0d", cap_data[5][63:0], exp5); end
         tests_run++; if (cap_data[6][63:0] !== 64'd6) begin tests_failed++; $display("FAIL err_beat6: got %0d expected 6", cap_data[6][63:0]); end
         tests_run++; if (errs != exp_errs) begin tests_failed++; $display("FAIL err_rx_count: got %0d expected %0d", errs, exp_errs); end
      end
      tests_run++; if (o_counter !== 64'd8) begin tests_failed++; $display("FAIL err_counter: got %0d expected 8", o_counter); end
      enable = 1'b0;
      cycle(1'b1, 1'b0);
   endtask

   initial begin
      resetn       = 1'b1;
      enable       = 1'b0;
      enable_w     = 1'b0;
      num_pkts     = 32'd0;
      num_pkts_w   = 32'd0;
      inject_err   = 1'b0;
      inject_err_w = 1'b0;
      eth.ready    = 1'b1;
      ethw.ready   = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_disable_mid();
      test_async_reset();
      test_wrap_back_to_back();
      test_err_inject();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ethnet_gen.md
Name: ethnet_gen

Overview:
- Transmit-side traffic generator for the QSFP/Ethernet NoC stream; drives a `t_ETH_STREAM.tx` NAP port.
- Emits fixed-length packets whose beat payload carries a 64-bit running beat counter in `data[63:0]`.
- The loopback receiver on the far end checks that each beat's `data[63:0]` matches its own counter.
- Sits beside the receive block in the loopback demo and closes the transmit half of the path.

Parameters:
- `PKT_BEATS`, 8, beats per packet (≥1).
- `GAP_CYCLES`, 4, idle cycles inserted after each packet's eop beat is accepted (0 allowed).
- `DEST_ADDR`, 4'h0, value driven on `tx.addr` for every beat.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  level; generator runs while high.
- `num_pkts`  in  32  packets per run; 0 = continuous.
- `inject_err`  in  1  one-cycle pulse requesting a corrupted beat (used only with the optional feature).
- `busy`  out  1  high in SEND or GAP.
- `done`  out  1  sticky; set when a finite run completes.
- `o_pkt_count`  out  32  packets fully accepted (eop handshakes).
- `o_counter`  out  64  beats accepted.
- `tx`  `t_ETH_STREAM.tx`  -  drives `valid`, `data[255:0]`, `addr[3:0]`, `sop`, `eop`; samples `ready`.

Behaviour:
- **Clock and reset:** one clock, `clk`; reset `resetn` is asynchronous and active-low.
- **Reset values:**
  - `tx.valid`, `tx.sop`, `tx.eop`, `tx.data`, `tx.addr` = 0.
  - `busy` = 0, `done` = 0.
  - `o_pkt_count` = 0, `o_counter` = 0.
  - Beat index = 0; state = IDLE.
- **Reset mid-packet:** all state is cleared immediately; no partial packet is resumed.
- **Handshake:**
  - A beat transfers on a rising edge where `tx.valid` and `tx.ready` are both 1.
  - Once `valid` is asserted, `valid`/`data`/`addr`/`sop`/`eop` stay stable until that transfer.
  - `valid` never drops without a transfer.
- **Outputs are registered.** First `valid` appears 1 cycle after the IDLE→SEND decision.
- **Beat content:**
  - `data[63:0]` = `o_counter` value at the time of transfer; `o_counter` increments on each transfer.
  - `data[95:64]` = `o_pkt_count`; `data[255:96]` = 0.
  - `addr` = `DEST_ADDR`.
  - `sop` = 1 on beat 0 only; `eop` = 1 on beat `PKT_BEATS`-1 only; both are 1 when `PKT_BEATS` = 1.
- **FSM:**
  - IDLE: if `enable` and not `done` → SEND, beat index = 0.
  - SEND: on each transfer, beat index++. On the eop transfer: `o_pkt_count`++. Then:
    - If `num_pkts` ≠ 0 and the new `o_pkt_count` = `num_pkts` → set `done` → IDLE.
    - Else if `GAP_CYCLES` > 0 → GAP.
    - Else → SEND with the next packet's beat 0 presented the following cycle; `valid` is permitted to stay high back-to-back.
  - GAP: count `GAP_CYCLES` cycles with `valid` = 0, then → SEND if `enable`, else → IDLE.
- **`enable` deasserted mid-packet:** the current packet completes (no truncation); the FSM then goes to IDLE (GAP is still honoured first).
- **`done`:**
  - Cleared only by reset, or by `enable` low for ≥1 cycle while in IDLE.
  - A finite run restarts when `enable` rises again after that clear.
  - `o_pkt_count` resets to 0 on run restart; `o_counter` does not.
- **Wrap-around:** `o_counter` wraps 2^64-1 → 0; `o_pkt_count` wraps at 2^32 in continuous mode.
- **Changes during a run:** `num_pkts` changes are sampled only on the IDLE→SEND transition.

Optional Feature:
- Macro: `ETHNET_GEN_ERR_INJECT_EN`.
- **Defined:**
  - An `inject_err` pulse arms a flag.
  - The next beat presented with `valid` (a beat not yet presented) carries `data[63:0]` = counter XOR 64'h1.
  - The flag clears on that beat's transfer; `o_counter` still increments normally.
  - Pulses while the flag is armed are ignored.
- **Not defined:** `inject_err` is ignored and no flag logic is synthesized.

Test Plan:
- **Reset then basic run.** Hold `resetn` = 0; expect all outputs 0. Release; `PKT_BEATS`=4, `GAP_CYCLES`=2, `num_pkts`=2, `ready` always 1, `enable`=1.
  - Expect 8 beats with `data[63:0]` = 0..7.
  - `sop` on beats 0 and 4; `eop` on beats 3 and 7.
  - 2 idle cycles between packets.
  - Then `done`=1, `o_pkt_count`=2, `o_counter`=8.
- **Backpressure.** Toggle `ready` pseudo-randomly.
  - `valid`/`data` are held stable across every stall.
  - `data[63:0]` sequence stays gapless 0,1,2,…
- **Disable mid-packet.** Drop `enable` at beat 1 of a 4-beat packet.
  - Beats 2 and 3 are still sent with `eop` on beat 3, then GAP, then IDLE with `busy`=0.
- **Async reset mid-packet.** Assert `resetn` low between clock edges during beat 2.
  - `tx.valid` falls immediately.
  - After release and re-enable, the first beat has `sop`=1 and `data[63:0]`=0.
- **Wrap and back-to-back.** Force `o_counter` to 64'hFFFF_FFFF_FFFF_FFFE, `GAP_CYCLES`=0, `PKT_BEATS`=1.
  - Successive beats carry …FFFE, …FFFF, 0, with `valid` continuously high and `sop`=`eop`=1 on each.
- **Error injection (`ETHNET_GEN_ERR_INJECT_EN` defined).** Pulse `inject_err` before beat 5.
  - Beat 5 carries `data[63:0]`=4.
  - Beat 6 carries 6.
  - The receiver flags exactly one error.
